// File: rtl/cnn_layer_accel_net_tx_packer.sv
// Packs 16-bit result pixels into 128-bit network beats (lane 0 in the MSBs) behind a 2-entry output buffer.
// Define CNN_NET_TX_TRAILER_EN to append a 0xA5A5 + frame-beat-count trailer beat after each frame.
module cnn_layer_accel_net_tx_packer #(
  parameter int C_PAYLOAD_WIDTH = 128,
  parameter int C_PIXEL_WIDTH   = 16
) (
  input  logic                       network_clk,
  input  logic                       network_rst,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  input  logic [C_PIXEL_WIDTH-1:0]   pix_data,
  input  logic                       pix_last,
  output logic                       to_network_valid,
  input  logic                       to_network_accept,
  output logic [C_PAYLOAD_WIDTH-1:0] to_network_payload,
  output logic                       to_network_last,
  output logic [31:0]                beats_sent
);
  localparam int C_LANES = C_PAYLOAD_WIDTH / C_PIXEL_WIDTH;
  localparam int LW = (C_LANES > 1) ? $clog2(C_LANES) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(C_LANES - 1);

  typedef enum logic [0:0] {ST_FILL, ST_TRAILER} state_t;

  state_t                     state_q, state_nxt;
  logic [LW-1:0]              lane_q;
  logic [C_PAYLOAD_WIDTH-1:0] asm_q, beat_dat, push_dat;
  logic                       push, push_last, pop, xfer, complete;
  logic [C_PAYLOAD_WIDTH-1:0] buf_dat [2];
  logic                       buf_last [2];
  logic                       wr_ptr, rd_ptr;
  logic [1:0]                 cnt_q, cnt_nxt;
  logic                       ready_q;

`ifdef CNN_NET_TX_TRAILER_EN
  logic [31:0]                frame_cnt_q;
  logic [C_PAYLOAD_WIDTH-1:0] trailer_dat;
`endif

  assign xfer               = pix_valid & ready_q;
  assign pop                = to_network_valid & to_network_accept;
  assign complete           = xfer & (pix_last | (lane_q == LAST_LANE));
  assign pix_ready          = ready_q;
  assign to_network_valid   = (cnt_q != 2'd0);
  assign to_network_payload = buf_dat[rd_ptr];
  assign to_network_last    = buf_last[rd_ptr];

  always_comb begin
    state_nxt = state_q;
    push      = 1'b0;
    push_dat  = '0;
    push_last = 1'b0;
    beat_dat  = asm_q;
    if (xfer)
      beat_dat[C_PAYLOAD_WIDTH-1-int'(lane_q)*C_PIXEL_WIDTH -: C_PIXEL_WIDTH] = pix_data;
`ifdef CNN_NET_TX_TRAILER_EN
    trailer_dat = '0;
    trailer_dat[C_PAYLOAD_WIDTH-1 -: 16]  = 16'hA5A5;
    trailer_dat[C_PAYLOAD_WIDTH-17 -: 32] = frame_cnt_q;
`endif
    case (state_q)
      ST_FILL: begin
        if (complete) begin
          push     = 1'b1;
          push_dat = beat_dat;
`ifdef CNN_NET_TX_TRAILER_EN
          // The trailer carries the frame's last flag instead of the data beat.
          if (pix_last) state_nxt = ST_TRAILER;
`else
          push_last = pix_last;
`endif
        end
      end
      ST_TRAILER: begin
`ifdef CNN_NET_TX_TRAILER_EN
        if (cnt_q < 2'd2) begin
          push      = 1'b1;
          push_dat  = trailer_dat;
          push_last = 1'b1;
          state_nxt = ST_FILL;
        end
`endif
      end
      default: state_nxt = ST_FILL;
    endcase
    cnt_nxt = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge network_clk) begin
    if (network_rst) begin
      state_q     <= ST_FILL;
      lane_q      <= '0;
      asm_q       <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      cnt_q       <= 2'd0;
      ready_q     <= 1'b0;
      beats_sent  <= 32'd0;
      for (int i = 0; i < 2; i++) begin
        buf_dat[i]  <= '0;
        buf_last[i] <= 1'b0;
      end
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      // Registered and conservative: any free slot is enough for the next pixel.
      ready_q <= (state_nxt == ST_FILL) && (cnt_nxt < 2'd2);
      if (xfer) begin
        if (complete) begin
          lane_q <= '0;
          asm_q  <= '0;
        end else begin
          lane_q <= lane_q + 1'b1;
          asm_q  <= beat_dat;
        end
      end
      if (push) begin
        buf_dat[wr_ptr]  <= push_dat;
        buf_last[wr_ptr] <= push_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr     <= ~rd_ptr;
        beats_sent <= beats_sent + 32'd1;
      end
    end
  end

`ifdef CNN_NET_TX_TRAILER_EN
  always_ff @(posedge network_clk) begin
    if (network_rst)
      frame_cnt_q <= 32'd0;
    else if (push)
      frame_cnt_q <= (state_q == ST_TRAILER) ? 32'd0 : frame_cnt_q + 32'd1;
  end
`endif
endmodule

// File: tb/tb_cnn_layer_accel_net_tx_packer.sv
// Bench for cnn_layer_accel_net_tx_packer: vector table plus scoreboard of expected beats.
module tb_cnn_layer_accel_net_tx_packer;
`ifdef CNN_NET_TX_TRAILER_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif

  logic         network_clk = 1'b0;
  logic         network_rst;
  logic         pix_valid;
  logic         pix_ready;
  logic [15:0]  pix_data;
  logic         pix_last;
  logic         to_network_valid;
  logic         to_network_accept;
  logic [127:0] to_network_payload;
  logic         to_network_last;
  logic [31:0]  beats_sent;

  cnn_layer_accel_net_tx_packer dut (
    .network_clk        (network_clk),
    .network_rst        (network_rst),
    .pix_valid          (pix_valid),
    .pix_ready          (pix_ready),
    .pix_data           (pix_data),
    .pix_last           (pix_last),
    .to_network_valid   (to_network_valid),
    .to_network_accept  (to_network_accept),
    .to_network_payload (to_network_payload),
    .to_network_last    (to_network_last),
    .beats_sent         (beats_sent)
  );

  always #5 network_clk = ~network_clk;

  typedef struct {
    logic [127:0] pay;
    logic         last;
  } beat_t;

  typedef struct {
    int          npix;
    logic [15:0] base;
    bit          last;
    int          stall;
    int          beats;   // data beats, trailer excluded
  } vec_t;

  beat_t        exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [127:0] m_asm;
  int           m_lane;
  logic [31:0]  m_frame;
  vec_t         vecs[6];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_asm   = '0;
    m_lane  = 0;
    m_frame = 32'd0;
    exp_q.delete();
  endtask

  task automatic model_pix(input logic [15:0] d, input bit last);
    beat_t e;
    m_asm[127-m_lane*16 -: 16] = d;
    if (m_lane == 7 || last) begin
      e.pay  = m_asm;
      e.last = last & !TR;
      exp_q.push_back(e);
      m_frame++;
      if (last && TR) begin
        e.pay  = {16'hA5A5, m_frame, 80'h0};
        e.last = 1'b1;
        exp_q.push_back(e);
      end
      if (last) m_frame = 32'd0;
      m_asm  = '0;
      m_lane = 0;
    end else begin
      m_lane++;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the transfer edge.
  task automatic send_pix(input logic [15:0] d, input bit last);
    int guard = 0;
    pix_valid = 1'b1;
    pix_data  = d;
    pix_last  = last;
    while (!pix_ready && guard < 500) begin
      @(posedge network_clk); #1;
      guard++;
    end
    if (guard >= 500) begin
      check("send_timeout", 0, 1);
    end else begin
      @(posedge network_clk); #1;
      model_pix(d, last);
    end
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  task automatic drain(input string name);
    int guard = 0;
    to_network_accept = 1'b1;
    while (exp_q.size() != 0 && guard < 200) begin
      @(posedge network_clk); #1;
      guard++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // Scoreboard: compare every beat the network takes.
  always @(negedge network_clk) begin
    if (!network_rst && to_network_valid && to_network_accept) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", to_network_payload, 0);
      end else begin
        check("beat_payload", to_network_payload, exp_q[0].pay);
        check("beat_last", to_network_last, exp_q[0].last);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [31:0]  start;
    logic [127:0] head;
    //          npix base     last stall beats
    vecs[0] = '{8,  16'h0001, 1'b0, 0,  1};
    vecs[1] = '{10, 16'h0001, 1'b1, 0,  2};
    vecs[2] = '{32, 16'h0100, 1'b0, 20, 4};
    vecs[3] = '{1,  16'h1234, 1'b1, 0,  1};
    vecs[4] = '{13, 16'h4000, 1'b1, 0,  2};
    vecs[5] = '{24, 16'h0200, 1'b1, 0,  3};

    network_rst       = 1'b1;
    pix_valid         = 1'b0;
    pix_data          = '0;
    pix_last          = 1'b0;
    to_network_accept = 1'b0;
    model_reset();
    repeat (3) @(posedge network_clk);
    #1;
    check("rst_valid", to_network_valid, 0);
    check("rst_payload", to_network_payload, 0);
    check("rst_last", to_network_last, 0);
    check("rst_beats_sent", beats_sent, 0);
    check("rst_pix_ready", pix_ready, 0);
    network_rst = 1'b0;
    @(posedge network_clk); #1;
    check("ready_after_rst", pix_ready, 1);

    // Latency: beat visible right after the 8th transfer edge.
    for (int k = 1; k <= 7; k++) send_pix(16'(k), 1'b0);
    check("lat_valid_before", to_network_valid, 0);
    send_pix(16'd8, 1'b0);
    check("lat_valid_after", to_network_valid, 1);
    check("lat_payload", to_network_payload, 128'h0001_0002_0003_0004_0005_0006_0007_0008);
    check("lat_last", to_network_last, 0);
    drain("lat_drain");
    check("lat_beats_sent", beats_sent, 1);

    // Single last pixel: zero-padded beat.
    to_network_accept = 1'b0;
    send_pix(16'h1234, 1'b1);
    check("single_payload", to_network_payload, 128'h1234_0000_0000_0000_0000_0000_0000_0000);
    check("single_last", to_network_last, !TR);
    check("single_ready", pix_ready, !TR);
    drain("single_drain");

    for (int i = 0; i < 6; i++) begin
      start = beats_sent;
      to_network_accept = (vecs[i].stall == 0);
      fork
        begin
          for (int k = 0; k < vecs[i].npix; k++)
            send_pix(vecs[i].base + 16'(k), vecs[i].last && (k == vecs[i].npix - 1));
        end
        begin
          if (vecs[i].stall > 0) begin
            repeat (vecs[i].stall - 2) @(posedge network_clk);
            #1;
            head = to_network_payload;
            check("stall_ready_low", pix_ready, 0);
            check("stall_valid", to_network_valid, 1);
            check("stall_head_first", head, (exp_q.size() != 0) ? exp_q[0].pay : 128'hx);
            repeat (2) @(posedge network_clk);
            #1;
            check("stall_head_stable", to_network_payload, head);
            to_network_accept = 1'b1;
          end
        end
      join
      drain("vec_drain");
      check("vec_beats", beats_sent - start, vecs[i].beats + ((vecs[i].last && TR) ? 1 : 0));
    end

    // Reset with one beat buffered and a 5-pixel partial beat.
    to_network_accept = 1'b0;
    for (int k = 0; k < 13; k++) send_pix(16'h0300 + 16'(k), 1'b0);
    check("pre_rst_valid", to_network_valid, 1);
    network_rst = 1'b1;
    @(posedge network_clk); #1;
    check("mid_rst_valid", to_network_valid, 0);
    check("mid_rst_beats_sent", beats_sent, 0);
    network_rst = 1'b0;
    model_reset();
    @(posedge network_clk); #1;
    check("mid_rst_ready", pix_ready, 1);
    to_network_accept = 1'b1;
    for (int k = 0; k < 8; k++) send_pix(16'h0500 + 16'(k), 1'b0);
    drain("post_rst_drain");
    check("post_rst_beats_sent", beats_sent, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cnn_layer_accel_net_tx_packer.md
Name: cnn_layer_accel_net_tx_packer

Overview:
- Network-side transmitter for the accelerator's result stream.
- Packs 16-bit output pixels into 128-bit network beats, lane 0 in the MSBs, so the word order matches the inbound from_network_payload packing ([127:112] = first word, [15:0] = eighth word).
- Drives the to_network valid/accept/payload interface through a 2-entry output buffer. Packing continues while the network stalls for up to two beats.
- Sits between the quad's output pixel stream and the network interface, in the network_clk domain.

Parameters:
- C_PAYLOAD_WIDTH, 128, network beat width; integer multiple of C_PIXEL_WIDTH.
- C_PIXEL_WIDTH, 16, output pixel width.
- C_LANES, C_PAYLOAD_WIDTH / C_PIXEL_WIDTH (8), pixels per beat. Derived localparam, not overridable.

Ports:
- network_clk  in  1  sole clock; all logic on its rising edge.
- network_rst  in  1  reset, synchronous, active-high.
- pix_valid  in  1  output pixel valid.
- pix_ready  out  1  packer accepts the pixel this cycle.
- pix_data  in  C_PIXEL_WIDTH  pixel value.
- pix_last  in  1  final pixel of the frame (sampled with pix_valid & pix_ready).
- to_network_valid  out  1  beat available.
- to_network_accept  in  1  network takes the beat.
- to_network_payload  out  C_PAYLOAD_WIDTH  packed beat.
- to_network_last  out  1  beat is the last of the frame.
- beats_sent  out  32  beats popped since reset; wraps at 2^32.

Behaviour:
- Reset (network_rst=1 at a clock edge):
  - to_network_valid=0, to_network_payload=0, to_network_last=0, beats_sent=0, pix_ready=0.
  - Lane counter=0, assembly register=0, buffer empty, FSM=ST_FILL.
  - pix_ready goes to 1 the first cycle after reset deasserts.
- Reset mid-operation: the partial beat and buffered beats are discarded. to_network_valid is 0 in the cycle after the reset edge.
- A pixel transfer occurs when pix_valid & pix_ready.
  - Lane L (0..C_LANES-1) is written to payload bits [C_PAYLOAD_WIDTH-1-L*C_PIXEL_WIDTH -: C_PIXEL_WIDTH].
  - The lane counter then increments.
- Beat completion: the beat completes on a transfer with lane counter = C_LANES-1, or a transfer with pix_last=1.
  - On completion, the assembled beat is pushed into the buffer at that edge. Unwritten lanes are zero.
  - last flag = pix_last. The lane counter returns to 0 and the assembly register clears to 0.
- Latency: a completing transfer at edge t gives to_network_valid=1 after edge t when the buffer was empty. There is no combinational path from pix_* to to_network_*.
- Output buffer: 2-entry FIFO of {last, payload}.
  - to_network_valid = !empty. Payload and last come from the head entry.
  - Pop on to_network_valid & to_network_accept. beats_sent increments on each pop.
  - Head payload and last hold stable while valid & !accept.
  - Simultaneous push and pop with 1 entry: count stays 1, ordering preserved.
- pix_ready = (FSM==ST_FILL) & (buffer count < 2). It is a registered function of state. It is conservative: it deasserts when full even if the incoming pixel would not complete a beat.
- FSM states:
  - ST_FILL: normal packing. Moves to ST_TRAILER on a pix_last transfer, only when CNN_NET_TX_TRAILER_EN is defined.
  - ST_TRAILER: pix_ready=0; the trailer beat is pushed when the buffer has space. Then returns to ST_FILL.
  - Without the macro the FSM remains in ST_FILL.
- Frame beat counter (32-bit) counts beats pushed in the current frame, including the last. It clears after the trailer is pushed, or after the last beat when the feature is off.
- pix_last with lane counter=0 and no prior lanes cannot occur; a last transfer always writes its own lane.

Optional Feature:
- Macro: CNN_NET_TX_TRAILER_EN.
- Defined:
  - After each frame's last beat, one trailer beat is pushed with payload[127:112]=16'hA5A5, payload[111:80]=frame beat count (excluding trailer), remaining bits 0.
  - On the trailer beat, to_network_last=1; the data beat carrying pix_last then has to_network_last=0.
  - pix_ready=0 until the trailer is pushed.
- Undefined: no trailer, and to_network_last=1 on the beat carrying pix_last.

Test Plan:
- Stream pixels 1..8, pix_last=0, accept=1 → one beat 0x0001_0002_0003_0004_0005_0006_0007_0008, last=0, valid one cycle after the 8th transfer, beats_sent=1.
- Stream pixels 1..10, pix_last on 10 → beat0 as above. Beat1 = 0x0009_000A_0000_0000_0000_0000_0000_0000 with last=1 (macro off).
- accept=0 for 20 cycles while streaming 32 pixels:
  - pix_ready drops after 2 beats are buffered.
  - The head payload stays stable.
  - After accept=1, all 4 beats arrive in order with no loss or duplication.
- Single pixel 0x1234 with pix_last → one beat 0x1234 followed by 112 zero bits, last=1.
- network_rst pulsed after 5 pixels with 1 beat buffered → valid=0 next cycle, beats_sent=0. The next 8 pixels form a clean beat starting at lane 0.
- With CNN_NET_TX_TRAILER_EN, 24 pixels, last on the 24th → 3 data beats (last=0), then trailer 0xA5A5_00000003 followed by zeros, last=1. pix_ready=0 until the trailer is pushed.
